// File: rtl/lfsr_rand_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_rand_gen_if
//  Description : Control and stream bundle for lfsr_rand_gen.
//                Carries the seed port, the enable, the valid/ready sample
//                stream and the live LFSR register view.
//                master : driven by the consumer/controller
//                slave  : driven by the generator
//  Signals     : enable, seed_load, seed_ch, seed, out_ready   (master -> slave)
//                out_valid, out_data, out_ch, lfsr_state       (slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface lfsr_rand_gen_if #(
    parameter int WIDTH  = 9,
    parameter int NUM_CH = 2
);
    // Channel index is at least one bit wide, even for a single channel.
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    enable;
    logic                    seed_load;
    logic [CHW-1:0]          seed_ch;
    logic [WIDTH-1:0]        seed;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CHW-1:0]          out_ch;
    logic [NUM_CH*WIDTH-1:0] lfsr_state;

    modport master (
        output enable, seed_load, seed_ch, seed, out_ready,
        input  out_valid, out_data, out_ch, lfsr_state
    );

    modport slave (
        input  enable, seed_load, seed_ch, seed, out_ready,
        output out_valid, out_data, out_ch, lfsr_state
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_rand_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_rand_gen
//  Description : Multi-channel Fibonacci XNOR LFSR pseudo-random source.
//                Channels are served round-robin; the current channel is
//                stepped STRIDE times per sample, the result is presented on
//                a valid/ready stream, then the next channel takes its turn.
//                An all-ones state (the XNOR lockup state) is escaped by
//                shifting in a 0 instead of the computed feedback.
//  Ports       : Clk      - system clock, rising edge
//                Reset_n  - asynchronous active-low reset
//                bus      - lfsr_rand_gen_if.slave (enable, seed port,
//                           sample stream, live LFSR registers)
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_rand_gen #(
    parameter int                WIDTH        = 9,
    parameter logic [WIDTH-1:0]  TAPS         = 9'h108,
    parameter int                NUM_CH       = 2,
    parameter int                STRIDE       = 4,
    parameter int unsigned       SEED_DEFAULT = 9'h001
) (
    input  wire              Clk,
    input  wire              Reset_n,
    lfsr_rand_gen_if.slave   bus
);

    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNTW = (STRIDE > 1) ? $clog2(STRIDE + 1) : 1;

    localparam logic [CNTW-1:0] c_LAST_STEP  = CNTW'(STRIDE - 1);
    localparam logic [CHW-1:0]  c_LAST_CH    = CHW'(NUM_CH - 1);
    localparam logic [CHW:0]    c_NUM_CH_EXT = (CHW + 1)'(NUM_CH);

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_PRESENT = 1'b1;

    logic [NUM_CH-1:0][WIDTH-1:0] r_state;
    logic [0:0]                   r_fsm;
    logic [CNTW-1:0]              r_step_cnt;
    logic [CHW-1:0]               r_cur_ch;
    logic                         r_out_valid;
    logic [WIDTH-1:0]             r_out_data;
    logic [CHW-1:0]               r_out_ch;

    logic [WIDTH-1:0]             w_stepped;
    logic                         w_seed_ok;
    logic                         w_seed_cur;
    logic                         w_run_step;

    // One XNOR Fibonacci step; all-ones would map to itself, so its
    // feedback is inverted to force a 0 in and leave the lockup state.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ~^(s & TAPS);
        if (&s) begin
            fb = ~fb;
        end
        return {s[WIDTH-2:0], fb};
    endfunction

    assign w_stepped  = f_step(r_state[r_cur_ch]);
    // Out-of-range channel numbers are dropped here so they touch nothing.
    assign w_seed_ok  = bus.seed_load && ({1'b0, bus.seed_ch} < c_NUM_CH_EXT);
    assign w_seed_cur = w_seed_ok && (bus.seed_ch == r_cur_ch);
    // A seed aimed at the stepping channel wins over the step.
    assign w_run_step = (r_fsm == c_ST_RUN) && bus.enable && !w_seed_cur;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= WIDTH'(SEED_DEFAULT ^ $unsigned(c));
            end
            r_fsm       <= c_ST_RUN;
            r_step_cnt  <= '0;
            r_cur_ch    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_seed_ok && (bus.seed_ch == CHW'(c))) begin
                    r_state[c] <= bus.seed;
                end else if (w_run_step && (r_cur_ch == CHW'(c))) begin
                    r_state[c] <= w_stepped;
                end
            end

            case (r_fsm)
                c_ST_RUN: begin
                    if (w_seed_cur) begin
                        // Stride restarts from the freshly loaded seed.
                        r_step_cnt <= '0;
                    end else if (bus.enable) begin
                        if (r_step_cnt == c_LAST_STEP) begin
                            r_out_data  <= w_stepped;
                            r_out_ch    <= r_cur_ch;
                            r_out_valid <= 1'b1;
                            r_step_cnt  <= '0;
                            r_fsm       <= c_ST_PRESENT;
                        end else begin
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                end
                c_ST_PRESENT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_cur_ch    <= (r_cur_ch == c_LAST_CH) ? '0 : r_cur_ch + 1'b1;
                        r_fsm       <= c_ST_RUN;
                    end
                end
                default: begin
                    r_fsm <= c_ST_RUN;
                end
            endcase
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_ch     = r_out_ch;
    assign bus.lfsr_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rand_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_rand_gen
//  Description : Self-checking bench for lfsr_rand_gen. Two instances:
//                dut1 with default parameters, dut2 with NUM_CH=3, STRIDE=1.
//                A sample-level reference model (per-channel state at the
//                start of each stride) predicts every emitted sample.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_rand_gen;

    localparam int W    = 9;
    localparam int TAPS = 'h108;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    int   m1[2];
    int   m1_cur;
    int   m2[3];
    int   m2_cur;

    lfsr_rand_gen_if #(.WIDTH(9), .NUM_CH(2)) bus1();
    lfsr_rand_gen_if #(.WIDTH(9), .NUM_CH(3)) bus2();

    lfsr_rand_gen #(.WIDTH(9), .TAPS(9'h108), .NUM_CH(2), .STRIDE(4), .SEED_DEFAULT(9'h001))
        dut1 (.Clk(clk), .Reset_n(rst_n), .bus(bus1));
    lfsr_rand_gen #(.WIDTH(9), .TAPS(9'h108), .NUM_CH(3), .STRIDE(1), .SEED_DEFAULT(9'h001))
        dut2 (.Clk(clk), .Reset_n(rst_n), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference LFSR step: count tapped ones, even count -> feed 1 (XNOR),
    // except that all-ones always feeds 0.
    function automatic int ref_step(input int s);
        int ones;
        int fb;
        ones = 0;
        for (int b = 0; b < W; b++) begin
            if (((s >> b) & 1) == 1 && ((TAPS >> b) & 1) == 1) ones++;
        end
        fb = (ones % 2 == 0) ? 1 : 0;
        if (s == (1 << W) - 1) fb = 0;
        return ((s * 2) + fb) % (1 << W);
    endfunction

    function automatic int ref_stride(input int s, input int n);
        int v;
        v = s;
        for (int k = 0; k < n; k++) v = ref_step(v);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) m1[c] = 1 ^ c;
        for (int c = 0; c < 3; c++) m2[c] = 1 ^ c;
        m1_cur = 0;
        m2_cur = 0;
    endtask

    // Drive one clock: inputs applied at a falling edge, DUT samples at the
    // rising edge, returns at the next falling edge. Seed strobes last one cycle.
    task automatic cyc(input logic en1, input logic rdy1, input logic en2, input logic rdy2);
        bus1.enable    = en1;
        bus1.out_ready = rdy1;
        bus2.enable    = en2;
        bus2.out_ready = rdy2;
        @(negedge clk);
        bus1.seed_load = 1'b0;
        bus2.seed_load = 1'b0;
    endtask

    task automatic wait_v1(input logic en, input int maxc, output int took);
        took = 0;
        while (bus1.out_valid !== 1'b1 && took < maxc) begin
            cyc(en, 1'b0, 1'b0, 1'b0);
            took++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [17:0] e1;
        logic [26:0] e2;
        @(negedge clk);
        @(negedge clk);
        e1 = {9'(m1[1]), 9'(m1[0])};
        e2 = {9'(m2[2]), 9'(m2[1]), 9'(m2[0])};
        n_vec++;
        if (bus1.out_valid !== 1'b0 || bus1.out_data !== 9'h000 || bus1.out_ch !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: got v=%b d=%h ch=%h expected v=0 d=000 ch=0",
                     bus1.out_valid, bus1.out_data, bus1.out_ch);
        end
        n_vec++;
        if (bus1.lfsr_state !== e1) begin
            n_err++;
            $display("FAIL reset_state1: got %h expected %h", bus1.lfsr_state, e1);
        end
        n_vec++;
        if (bus2.lfsr_state !== e2 || bus2.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state2: got %h v=%b expected %h v=0", bus2.lfsr_state, bus2.out_valid, e2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [8:0]  exp;
        logic [17:0] e1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus1.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_valid: got %b expected 0", bus1.out_valid);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        exp = 9'(ref_stride(m1[0], 4));
        m1[0] = int'(exp);
        n_vec++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== exp || bus1.out_ch !== 1'b0) begin
            n_err++;
            $display("FAIL first_sample: got v=%b d=%h ch=%h expected v=1 d=%h ch=0",
                     bus1.out_valid, bus1.out_data, bus1.out_ch, exp);
        end
        n_vec++;
        if (bus1.out_data !== 9'h01E) begin
            n_err++;
            $display("FAIL first_value: got %h expected 01e", bus1.out_data);
        end
        e1 = {9'(m1[1]), 9'(m1[0])};
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (bus1.out_valid !== 1'b1 || bus1.out_data !== exp || bus1.out_ch !== 1'b0 ||
                bus1.lfsr_state !== e1) begin
                n_err++;
                $display("FAIL hold: got v=%b d=%h st=%h expected v=1 d=%h st=%h",
                         bus1.out_valid, bus1.out_data, bus1.lfsr_state, exp, e1);
            end
        end
    endtask

    task automatic test_handshake();
        logic [8:0] exp;
        int took;
        for (int s = 0; s < 2; s++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            m1_cur = (m1_cur + 1) % 2;
            n_vec++;
            if (bus1.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hs_drop: got %b expected 0", bus1.out_valid);
            end
            wait_v1(1'b1, 20, took);
            n_vec++;
            if (took != 4) begin
                n_err++;
                $display("FAIL latency: got %0d expected 4", took);
            end
            exp = 9'(ref_stride(m1[m1_cur], 4));
            m1[m1_cur] = int'(exp);
            n_vec++;
            if (bus1.out_data !== exp || bus1.out_ch !== 1'(m1_cur)) begin
                n_err++;
                $display("FAIL hs_sample: got d=%h ch=%h expected d=%h ch=%0d",
                         bus1.out_data, bus1.out_ch, exp, m1_cur);
            end
        end
    endtask

    task automatic test_lockup();
        logic [8:0] exp;
        int took;
        int n0;
        bit seen1ff;
        bit acc;
        // Accept the pending ch0 sample, then the ch1 sample, landing in RUN on ch0.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        m1_cur = 1;
        wait_v1(1'b1, 20, took);
        exp = 9'(ref_stride(m1[1], 4));
        m1[1] = int'(exp);
        n_vec++;
        if (bus1.out_data !== exp || bus1.out_ch !== 1'b1) begin
            n_err++;
            $display("FAIL lk_pre: got d=%h ch=%h expected d=%h ch=1", bus1.out_data, bus1.out_ch, exp);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        m1_cur = 0;
        bus1.seed_load = 1'b1;
        bus1.seed_ch   = 1'b0;
        bus1.seed      = 9'h1FF;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        m1[0] = 'h1FF;
        n_vec++;
        if (bus1.lfsr_state[8:0] !== 9'h1FF) begin
            n_err++;
            $display("FAIL lk_seed: got %h expected 1ff", bus1.lfsr_state[8:0]);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus1.lfsr_state[8:0] !== 9'(ref_step(m1[0]))) begin
            n_err++;
            $display("FAIL lk_escape: got %h expected %h", bus1.lfsr_state[8:0], 9'(ref_step(m1[0])));
        end
        n0 = 0;
        seen1ff = 1'b0;
        for (int i = 0; i < 3000 && n0 < 160; i++) begin
            if (bus1.lfsr_state[8:0] === 9'h1FF) seen1ff = 1'b1;
            acc = 1'b0;
            if (bus1.out_valid === 1'b1) begin
                exp = 9'(ref_stride(m1[m1_cur], 4));
                m1[m1_cur] = int'(exp);
                n_vec++;
                if (bus1.out_data !== exp || bus1.out_ch !== 1'(m1_cur)) begin
                    n_err++;
                    $display("FAIL lk_sample: got d=%h ch=%h expected d=%h ch=%0d",
                             bus1.out_data, bus1.out_ch, exp, m1_cur);
                end
                if (m1_cur == 0) n0++;
                acc = 1'b1;
            end
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (acc) m1_cur = (m1_cur + 1) % 2;
        end
        n_vec++;
        if (n0 != 160 || seen1ff) begin
            n_err++;
            $display("FAIL lk_run: got n0=%0d seen1ff=%0d expected n0=160 seen1ff=0", n0, seen1ff);
        end
    endtask

    task automatic test_random();
        logic [8:0] pexp;
        bit pend;
        bit acc;
        logic en;
        logic rdy;
        int sch;
        int sv;
        int nsamp;
        pend = 1'b0;
        pexp = '0;
        nsamp = 0;
        for (int i = 0; i < 600; i++) begin
            if (bus1.out_valid === 1'b1) begin
                if (!pend) begin
                    pexp = 9'(ref_stride(m1[m1_cur], 4));
                    m1[m1_cur] = int'(pexp);
                    pend = 1'b1;
                    nsamp++;
                end
                n_vec++;
                if (bus1.out_data !== pexp || bus1.out_ch !== 1'(m1_cur)) begin
                    n_err++;
                    $display("FAIL rnd_sample: got d=%h ch=%h expected d=%h ch=%0d",
                             bus1.out_data, bus1.out_ch, pexp, m1_cur);
                end
            end
            en  = ($urandom_range(3, 0) != 0);
            rdy = ($urandom_range(2, 0) == 0);
            if ($urandom_range(7, 0) == 0) begin
                sch = int'($urandom_range(1, 0));
                sv  = int'($urandom_range(511, 0));
                bus1.seed_load = 1'b1;
                bus1.seed_ch   = 1'(sch);
                bus1.seed      = 9'(sv);
                m1[sch] = sv;
            end
            acc = (bus1.out_valid === 1'b1) && rdy;
            cyc(en, rdy, 1'b0, 1'b0);
            if (acc) begin
                m1_cur = (m1_cur + 1) % 2;
                pend = 1'b0;
            end
        end
        n_vec++;
        if (nsamp < 20) begin
            n_err++;
            $display("FAIL rnd_count: got %0d expected >=20", nsamp);
        end
    endtask

    task automatic test_seed_mid();
        logic [8:0]  exp;
        logic [26:0] e2;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        bus1.seed_load = 1'b1;
        bus1.seed_ch   = 1'b0;
        bus1.seed      = 9'h0AA;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        m1[0] = 'h0AA;
        n_vec++;
        if (bus1.lfsr_state[8:0] !== 9'h0AA || bus1.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sm_load: got st=%h v=%b expected st=0aa v=0", bus1.lfsr_state[8:0], bus1.out_valid);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus1.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sm_restart: got v=%b expected 0", bus1.out_valid);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        exp = 9'(ref_stride(m1[0], 4));
        m1[0] = int'(exp);
        n_vec++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== exp || bus1.out_ch !== 1'b0) begin
            n_err++;
            $display("FAIL sm_sample: got v=%b d=%h expected v=1 d=%h", bus1.out_valid, bus1.out_data, exp);
        end
        bus1.seed_load = 1'b1;
        bus1.seed_ch   = 1'b0;
        bus1.seed      = 9'h155;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        m1[0] = 'h155;
        n_vec++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== exp || bus1.lfsr_state[8:0] !== 9'h155) begin
            n_err++;
            $display("FAIL sm_present: got v=%b d=%h st=%h expected v=1 d=%h st=155",
                     bus1.out_valid, bus1.out_data, bus1.lfsr_state[8:0], exp);
        end
        bus2.seed_load = 1'b1;
        bus2.seed_ch   = 2'd3;
        bus2.seed      = 9'h1FF;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        e2 = {9'(m2[2]), 9'(m2[1]), 9'(m2[0])};
        n_vec++;
        if (bus2.lfsr_state !== e2) begin
            n_err++;
            $display("FAIL sm_badch: got %h expected %h", bus2.lfsr_state, e2);
        end
    endtask

    task automatic test_async_reset();
        logic [17:0] e1;
        n_vec++;
        if (bus1.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ar_pre: got v=%b expected 1", bus1.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        e1 = {9'(m1[1]), 9'(m1[0])};
        n_vec++;
        if (bus1.out_valid !== 1'b0 || bus1.out_data !== 9'h000 || bus1.out_ch !== 1'b0 ||
            bus1.lfsr_state !== e1) begin
            n_err++;
            $display("FAIL async_rst: got v=%b d=%h st=%h expected v=0 d=000 st=%h",
                     bus1.out_valid, bus1.out_data, bus1.lfsr_state, e1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_enable_toggle();
        logic       pat[7];
        logic [8:0] exp;
        int ones;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp = 9'(ref_stride(m1[0], 4));
        ones = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(pat[i], 1'b0, 1'b0, 1'b0);
            if (pat[i]) ones++;
            n_vec++;
            if (bus1.out_valid !== ((ones == 4) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL tog_valid: step %0d got %b expected %0d", i, bus1.out_valid, ones == 4);
            end
        end
        m1[0] = int'(exp);
        n_vec++;
        if (bus1.out_data !== exp) begin
            n_err++;
            $display("FAIL tog_data: got %h expected %h", bus1.out_data, exp);
        end
    endtask

    task automatic test_stride1();
        int  s0[512];
        bit  seen[512];
        int  n0;
        int  gap;
        int  maxgap;
        int  dups;
        bit  has1ff;
        logic [8:0] exp;
        bus2.seed_load = 1'b1;
        bus2.seed_ch   = 2'd0;
        bus2.seed      = 9'h001;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        m2[0] = 1;
        n0 = 0;
        gap = 0;
        maxgap = 0;
        for (int i = 0; i < 4000 && n0 < 512; i++) begin
            if (bus2.out_valid === 1'b1) begin
                exp = 9'(ref_stride(m2[m2_cur], 1));
                m2[m2_cur] = int'(exp);
                n_vec++;
                if (bus2.out_data !== exp || bus2.out_ch !== 2'(m2_cur)) begin
                    n_err++;
                    $display("FAIL s1_sample: got d=%h ch=%h expected d=%h ch=%0d",
                             bus2.out_data, bus2.out_ch, exp, m2_cur);
                end
                if (m2_cur == 0) begin
                    s0[n0] = int'(bus2.out_data);
                    n0++;
                end
                m2_cur = (m2_cur + 1) % 3;
                gap = 0;
            end else begin
                gap++;
                if (gap > maxgap) maxgap = gap;
            end
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
        end
        n_vec++;
        if (n0 != 512 || maxgap > 1) begin
            n_err++;
            $display("FAIL s1_flow: got n0=%0d maxgap=%0d expected n0=512 maxgap<=1", n0, maxgap);
        end
        dups = 0;
        has1ff = 1'b0;
        for (int k = 0; k < 512; k++) seen[k] = 1'b0;
        for (int k = 0; k < 511 && k < n0; k++) begin
            if (seen[s0[k]]) dups++;
            seen[s0[k]] = 1'b1;
            if (s0[k] == 'h1FF) has1ff = 1'b1;
        end
        n_vec++;
        if (dups != 0 || has1ff) begin
            n_err++;
            $display("FAIL s1_period: got dups=%0d has1ff=%0d expected 0 0", dups, has1ff);
        end
        n_vec++;
        if (n0 == 512 && s0[511] != s0[0]) begin
            n_err++;
            $display("FAIL s1_wrap: got %h expected %h", s0[511], s0[0]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus1.enable = 1'b0; bus1.out_ready = 1'b0; bus1.seed_load = 1'b0;
        bus1.seed_ch = '0;  bus1.seed = '0;
        bus2.enable = 1'b0; bus2.out_ready = 1'b0; bus2.seed_load = 1'b0;
        bus2.seed_ch = '0;  bus2.seed = '0;
        model_reset();
        test_reset();
        test_basic();
        test_handshake();
        test_lockup();
        do_reset();
        test_random();
        do_reset();
        test_seed_mid();
        test_async_reset();
        test_enable_toggle();
        do_reset();
        test_stride1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
